// File: rtl/ha_fa_reg.sv
// ha_fa_reg -- registered ripple-carry adder built from two half-adder
// stages per bit, with a valid-qualified output register.
//
// Each bit i:
//   HA1: p_i = a_i ^ b_i,  g_i = a_i & b_i
//   HA2: s_i = p_i ^ c_i,  c_{i+1} = g_i | (p_i & c_i)
//   c_0 = cin, carry = c_WIDTH, so {carry, sum} == a + b + cin.
//
// Parameters:
//   WIDTH      operand width in bits (>= 1); WIDTH=1 is the classic full adder
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset, clears every register
//   in_valid   qualifies a/b/cin this cycle
//   a, b       operands (WIDTH bits)
//   cin        carry into bit 0
//   out_valid  sum/carry hold a new result this cycle
//   sum        registered (a+b+cin)[WIDTH-1:0]
//   carry      registered (a+b+cin)[WIDTH]
//
// Build option:
//   HA_FA_PIPE2_EN  when defined, operands are registered first and the add
//                   result one cycle later (latency 2). Undefined: the add
//                   result is registered directly (latency 1).

module ha_fa_reg #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    output logic [WIDTH-1:0] sum,
    output logic             carry
);

    // Operands feeding the adder core and their qualifier.
    logic [WIDTH-1:0] add_a;
    logic [WIDTH-1:0] add_b;
    logic             add_cin;
    logic             add_valid;

`ifdef HA_FA_PIPE2_EN
    logic [WIDTH-1:0] op_a_q,     op_a_d;
    logic [WIDTH-1:0] op_b_q,     op_b_d;
    logic             op_cin_q,   op_cin_d;
    logic             op_valid_q, op_valid_d;

    // Operand stage holds its contents when nothing valid arrives, so
    // garbage on the inputs during idle cycles never enters the pipeline.
    always_comb begin
        op_a_d     = op_a_q;
        op_b_d     = op_b_q;
        op_cin_d   = op_cin_q;
        op_valid_d = in_valid;
        if (in_valid) begin
            op_a_d   = a;
            op_b_d   = b;
            op_cin_d = cin;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_a_q     <= '0;
            op_b_q     <= '0;
            op_cin_q   <= 1'b0;
            op_valid_q <= 1'b0;
        end else begin
            op_a_q     <= op_a_d;
            op_b_q     <= op_b_d;
            op_cin_q   <= op_cin_d;
            op_valid_q <= op_valid_d;
        end
    end

    assign add_a     = op_a_q;
    assign add_b     = op_b_q;
    assign add_cin   = op_cin_q;
    assign add_valid = op_valid_q;
`else
    assign add_a     = a;
    assign add_b     = b;
    assign add_cin   = cin;
    assign add_valid = in_valid;
`endif

    // Ripple-carry core. The carry is walked through a single variable
    // inside one process so there is no bit-level self-loop on a vector.
    logic [WIDTH-1:0] sum_c;
    logic             carry_c;
    logic             p_bit;
    logic             g_bit;
    logic             c_rip;

    always_comb begin
        sum_c = '0;
        p_bit = 1'b0;
        g_bit = 1'b0;
        c_rip = add_cin;
        for (int i = 0; i < WIDTH; i++) begin
            p_bit    = add_a[i] ^ add_b[i];
            g_bit    = add_a[i] & add_b[i];
            sum_c[i] = p_bit ^ c_rip;
            c_rip    = g_bit | (p_bit & c_rip);
        end
        carry_c = c_rip;
    end

    logic [WIDTH-1:0] sum_q,   sum_d;
    logic             carry_q, carry_d;
    logic             valid_q, valid_d;

    always_comb begin
        sum_d   = sum_q;
        carry_d = carry_q;
        valid_d = add_valid;
        if (add_valid) begin
            sum_d   = sum_c;
            carry_d = carry_c;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q   <= '0;
            carry_q <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            sum_q   <= sum_d;
            carry_q <= carry_d;
            valid_q <= valid_d;
        end
    end

    assign sum       = sum_q;
    assign carry     = carry_q;
    assign out_valid = valid_q;

endmodule

// File: tb/tb_ha_fa_reg.sv
// Testbench for ha_fa_reg: a WIDTH=1 and a WIDTH=8 instance share clock,
// reset, in_valid and cin. A queue-based reference model delays the
// arithmetic result a+b+cin by the build's latency.

module tb_ha_fa_reg;

`ifdef HA_FA_PIPE2_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       cin;
    logic [0:0] a1, b1, s1;
    logic       c1, ov1;
    logic [7:0] a8, b8, s8;
    logic       c8, ov8;

    ha_fa_reg #(.WIDTH(1)) u_w1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
        .a(a1), .b(b1), .cin(cin),
        .out_valid(ov1), .sum(s1), .carry(c1)
    );

    ha_fa_reg #(.WIDTH(8)) u_w8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
        .a(a8), .b(b8), .cin(cin),
        .out_valid(ov8), .sum(s8), .carry(c8)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic       v;
        logic [1:0] r1;
        logic [8:0] r8;
    } ent_t;

    ent_t       pipe_q[$];
    logic       exp_v;
    logic [1:0] exp_r1;
    logic [8:0] exp_r8;
    int         n_cmp;
    int         n_err;

    task automatic model_reset();
        ent_t e;
        pipe_q.delete();
        e.v  = 1'b0;
        e.r1 = '0;
        e.r8 = '0;
        for (int i = 0; i < LAT - 1; i++) pipe_q.push_back(e);
        exp_v  = 1'b0;
        exp_r1 = '0;
        exp_r8 = '0;
    endtask

    // Advance one clock, update the model, return at posedge+1.
    task automatic tick();
        ent_t e;
        ent_t o;
        @(posedge clk);
        if (rst_n) begin
            e.v  = in_valid;
            e.r1 = 2'(a1) + 2'(b1) + 2'(cin);
            e.r8 = 9'(a8) + 9'(b8) + 9'(cin);
            pipe_q.push_back(e);
            o = pipe_q.pop_front();
            exp_v = o.v;
            if (o.v) begin
                exp_r1 = o.r1;
                exp_r8 = o.r8;
            end
        end
        #1;
    endtask

    task automatic drive(input logic v, input logic [0:0] ia1, input logic [0:0] ib1,
                         input logic [7:0] ia8, input logic [7:0] ib8, input logic ic);
        in_valid = v;
        a1 = ia1; b1 = ib1; a8 = ia8; b8 = ib8; cin = ic;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        model_reset();
        drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if ({ov1, c1, s1} !== 3'b000) begin
            n_err++;
            $display("FAIL reset_w1: got v/c/s=%b%b%b want 000", ov1, c1, s1);
        end
        n_cmp++;
        if ({ov8, c8, s8} !== 10'h000) begin
            n_err++;
            $display("FAIL reset_w8: got v=%b c=%b s=%h want 0/0/00", ov8, c8, s8);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_exhaustive_w1();
        logic [1:0] tbl [8];
        logic [2:0] k;
        int idx;
        // {carry,sum} for a,b,cin = 000..111
        tbl = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};
        idx = 0;
        for (int t = 0; t < 8 + LAT - 1; t++) begin
            if (t < 8) begin
                k = 3'(t);
                drive(1'b1, k[2], k[1], 8'($urandom), 8'($urandom), k[0]);
            end else begin
                drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
            end
            tick();
            n_cmp++;
            if ({ov1, c1, s1} !== {exp_v, exp_r1}) begin
                n_err++;
                $display("FAIL exh_w1_model t=%0d: got v/c/s=%b%b%b want %b%b", t, ov1, c1, s1, exp_v, exp_r1);
            end
            if (exp_v) begin
                n_cmp++;
                if ({ov1, c1, s1} !== {1'b1, tbl[idx]}) begin
                    n_err++;
                    $display("FAIL exh_w1_table idx=%0d: got v/c/s=%b%b%b want 1%b", idx, ov1, c1, s1, tbl[idx]);
                end
                idx++;
            end
        end
        n_cmp++;
        if (idx != 8) begin
            n_err++;
            $display("FAIL exh_w1_count: got %0d results want 8", idx);
        end
    endtask

    task automatic test_w8_corners();
        logic [8:0] want [2];
        logic [7:0] ta [2];
        logic [7:0] tb [2];
        logic       tc [2];
        int idx;
        ta = '{8'hFF, 8'hFF};
        tb = '{8'h01, 8'hFF};
        tc = '{1'b0, 1'b1};
        want = '{9'h100, 9'h1FF};
        idx = 0;
        for (int t = 0; t < 2 + LAT - 1; t++) begin
            if (t < 2) drive(1'b1, 1'b0, 1'b0, ta[t], tb[t], tc[t]);
            else       drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
            tick();
            if (exp_v) begin
                n_cmp++;
                if ({ov8, c8, s8} !== {1'b1, want[idx]}) begin
                    n_err++;
                    $display("FAIL w8_corner%0d: got v=%b c=%b s=%h want 1/%b/%h", idx, ov8, c8, s8, want[idx][8], want[idx][7:0]);
                end
                idx++;
            end
        end
        n_cmp++;
        if (idx != 2) begin
            n_err++;
            $display("FAIL w8_corner_count: got %0d results want 2", idx);
        end
    endtask

    task automatic test_hold();
        drive(1'b1, 1'b1, 1'b1, 8'h01, 8'h01, 1'b0);
        tick();
        drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1);
        for (int t = 0; t < LAT + 1; t++) begin
            tick();
            a1 = 'x; b1 = 'x; a8 = 'x; b8 = 'x; cin = 1'bx;
        end
        n_cmp++;
        if ({ov1, c1, s1} !== 3'b010) begin
            n_err++;
            $display("FAIL hold_w1: got v/c/s=%b%b%b want 010", ov1, c1, s1);
        end
        n_cmp++;
        if ({ov8, c8, s8} !== {1'b0, 9'h002}) begin
            n_err++;
            $display("FAIL hold_w8: got v=%b c=%b s=%h want 0/0/02", ov8, c8, s8);
        end
    endtask

    task automatic test_async_reset();
        drive(1'b1, 1'b1, 1'b1, 8'h01, 8'h01, 1'b1);
        tick();
        drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
        for (int t = 1; t < LAT; t++) tick();
        n_cmp++;
        if ({ov1, c1, s1} !== 3'b111 || {ov8, c8, s8} !== {1'b1, 9'h003}) begin
            n_err++;
            $display("FAIL areset_pre: got w1=%b%b%b w8=%b/%b/%h want 111 and 1/0/03", ov1, c1, s1, ov8, c8, s8);
        end
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        n_cmp++;
        if ({ov1, c1, s1} !== 3'b000 || {ov8, c8, s8} !== 10'h000) begin
            n_err++;
            $display("FAIL areset_immediate: got w1=%b%b%b w8=%b/%b/%h want all 0", ov1, c1, s1, ov8, c8, s8);
        end
        @(negedge clk);
        rst_n = 1'b1;

        // Reset while a result is in flight: it must not reappear.
        drive(1'b1, 1'b1, 1'b1, 8'hA5, 8'h5A, 1'b1);
        tick();
        #2;
        rst_n = 1'b0;
        model_reset();
        drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
        #1;
        @(negedge clk);
        rst_n = 1'b1;
        for (int t = 0; t < LAT + 1; t++) begin
            tick();
            n_cmp++;
            if ({ov1, c1, s1} !== 3'b000 || {ov8, c8, s8} !== 10'h000) begin
                n_err++;
                $display("FAIL reset_midstream t=%0d: got w1=%b%b%b w8=%b/%b/%h want all 0", t, ov1, c1, s1, ov8, c8, s8);
            end
        end
    endtask

    task automatic test_random_stream();
        for (int t = 0; t < 1000 + LAT - 1; t++) begin
            if (t < 1000)
                drive(1'b1, 1'($urandom), 1'($urandom), 8'($urandom), 8'($urandom), 1'($urandom));
            else
                drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
            tick();
            n_cmp++;
            if ({ov8, c8, s8} !== {exp_v, exp_r8}) begin
                n_err++;
                $display("FAIL stream_w8 t=%0d: got v=%b c=%b s=%h want %b/%b/%h", t, ov8, c8, s8, exp_v, exp_r8[8], exp_r8[7:0]);
            end
            n_cmp++;
            if ({ov1, c1, s1} !== {exp_v, exp_r1}) begin
                n_err++;
                $display("FAIL stream_w1 t=%0d: got v/c/s=%b%b%b want %b%b", t, ov1, c1, s1, exp_v, exp_r1);
            end
        end
    endtask

    task automatic test_back_to_back();
        for (int t = 0; t < 300; t++) begin
            drive(1'(($urandom % 3) != 0), 1'($urandom), 1'($urandom), 8'($urandom), 8'($urandom), 1'($urandom));
            tick();
            n_cmp++;
            if ({ov8, c8, s8} !== {exp_v, exp_r8} || {ov1, c1, s1} !== {exp_v, exp_r1}) begin
                n_err++;
                $display("FAIL gaps t=%0d: got w8=%b/%b/%h w1=%b%b%b want %b/%b/%h %b%b",
                         t, ov8, c8, s8, ov1, c1, s1, exp_v, exp_r8[8], exp_r8[7:0], exp_v, exp_r1);
            end
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_exhaustive_w1();
        test_w8_corners();
        test_hold();
        test_async_reset();
        test_random_stream();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
